// File: rtl/axis_rr_arbiter.sv
// Two-input AXI-Stream round-robin arbiter with packet-locked grants.
// Two requesters share one master stream. The arbiter grants one requester at a
// time, holds that grant until a tlast beat completes, and then returns to IDLE
// for one cycle before it arbitrates again. It also counts the packets it
// forwards from each requester.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,

  input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                      s00_axis_tvalid,
  input  logic                      s00_axis_tlast,
  output logic                      s00_axis_tready,

  input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,
  input  logic                      s01_axis_tvalid,
  input  logic                      s01_axis_tlast,
  output logic                      s01_axis_tready,

  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,

  output logic [1:0]                grant,
  output logic [CNT_WIDTH-1:0]      pkt_cnt0,
  output logic [CNT_WIDTH-1:0]      pkt_cnt1
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  // Port that was granted most recently: 0 means s00, 1 means s01.
  // It resets to 1 so that s00 wins the first tie.
  logic   last_grant;

  logic   xfer_last0;
  logic   xfer_last1;

  // A packet ends when the granted port hands over a beat with tlast set.
  assign xfer_last0 = (state == GRANT0) && s00_axis_tvalid && m00_axis_tready && s00_axis_tlast;
  assign xfer_last1 = (state == GRANT1) && s01_axis_tvalid && m00_axis_tready && s01_axis_tlast;

  // Arbitration FSM. The grant register is updated together with the state,
  // and the packet counters advance when a packet ends.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 2'b00;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // m00_axis_tready is deliberately not consulted here.
          if (s00_axis_tvalid && (!s01_axis_tvalid || last_grant)) begin
            state      <= GRANT0;
            grant      <= 2'b01;
            last_grant <= 1'b0;
          end else if (s01_axis_tvalid) begin
            state      <= GRANT1;
            grant      <= 2'b10;
            last_grant <= 1'b1;
          end
        end
        GRANT0: begin
          if (xfer_last0) begin
            state    <= IDLE;
            grant    <= 2'b00;
            pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
          end
        end
        GRANT1: begin
          if (xfer_last1) begin
            state    <= IDLE;
            grant    <= 2'b00;
            pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Route the granted requester to the master stream. The master sees all
  // zeros while IDLE. Data and strobes pass through without being inspected.
  always_comb begin
    m00_axis_tdata  = '0;
    m00_axis_tstrb  = {STRB_WIDTH{1'b0}};
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    case (state)
      GRANT0: begin
        m00_axis_tdata  = s00_axis_tdata;
        m00_axis_tstrb  = s00_axis_tstrb;
        m00_axis_tvalid = s00_axis_tvalid;
        m00_axis_tlast  = s00_axis_tlast;
        s00_axis_tready = m00_axis_tready;
      end
      GRANT1: begin
        m00_axis_tdata  = s01_axis_tdata;
        m00_axis_tstrb  = s01_axis_tstrb;
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tlast  = s01_axis_tlast;
        s01_axis_tready = m00_axis_tready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard testbench for axis_rr_arbiter.
// Driver processes send queued beats on each requester. The directed tests
// push the expected master-side beats, in the order arbitration should
// produce them. A negedge monitor pops and compares each beat it sees and
// also checks the routing, idle and bubble behaviour every cycle.
`timescale 1ns/1ps
module tb_axis_rr_arbiter;

  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int CW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data  [2];
  logic [SW-1:0] s_strb  [2];
  logic          s_valid [2];
  logic          s_last  [2];
  logic          s00_rdy, s01_rdy;

  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  beat_t drv_q [2][$];
  exp_t  exp_q [$];
  bit    abort;
  bit    rdy_toggle;
  int    gap_cycles;
  int    checks;
  int    errors;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .axis_aclk       (clk),
    .axis_aresetn    (rst_n),
    .s00_axis_tdata  (s_data[0]),
    .s00_axis_tstrb  (s_strb[0]),
    .s00_axis_tvalid (s_valid[0]),
    .s00_axis_tlast  (s_last[0]),
    .s00_axis_tready (s00_rdy),
    .s01_axis_tdata  (s_data[1]),
    .s01_axis_tstrb  (s_strb[1]),
    .s01_axis_tvalid (s_valid[1]),
    .s01_axis_tlast  (s_last[1]),
    .s01_axis_tready (s01_rdy),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .grant           (grant),
    .pkt_cnt0        (pkt_cnt0),
    .pkt_cnt1        (pkt_cnt1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One requester driver. Each loop iteration covers one clock cycle. A beat
  // is dropped from the queue once its handshake is seen at the negedge.
  task automatic drive_port(input int p);
    beat_t b;
    int    gap_left;
    bit    loaded;
    logic  rdy;
    loaded = 1'b0;
    gap_left = 0;
    forever begin
      @(posedge clk); #1;
      if (abort || drv_q[p].size() == 0) begin
        s_valid[p] = 1'b0;
        s_last[p]  = 1'b0;
        s_data[p]  = 32'hDEAD_0000 | DW'(p);
        s_strb[p]  = '0;
        loaded     = 1'b0;
        continue;
      end
      if (!loaded) begin
        gap_left = drv_q[p][0].gap;
        loaded   = 1'b1;
      end
      if (gap_left > 0) begin
        gap_left--;
        s_valid[p] = 1'b0;
        s_last[p]  = 1'b0;
        continue;
      end
      b = drv_q[p][0];
      s_valid[p] = 1'b1;
      s_data[p]  = b.data;
      s_strb[p]  = b.strb;
      s_last[p]  = b.last;
      @(negedge clk);
      rdy = (p == 0) ? s00_rdy : s01_rdy;
      if (!abort && rdy && drv_q[p].size() > 0) begin
        b = drv_q[p].pop_front();
        loaded = 1'b0;
      end
    end
  endtask

  initial drive_port(0);
  initial drive_port(1);

  // Toggle the master ready every cycle when that mode is enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_toggle) m_tready = ~m_tready;
    end
  end

  // Monitor: per-cycle routing checks and scoreboard comparison of beats.
  bit last_xfer_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_xfer_prev = 1'b0;
    end else begin
      case (grant)
        2'b00: check("idle_outputs", {s00_rdy, s01_rdy, m_tvalid, m_tlast, m_tstrb, m_tdata},
                     {4'b0000, {SW{1'b0}}, {DW{1'b0}}});
        2'b01: check("route_s00", {s00_rdy, s01_rdy, m_tvalid, m_tlast, m_tstrb, m_tdata},
                     {m_tready, 1'b0, s_valid[0], s_last[0], s_strb[0], s_data[0]});
        2'b10: check("route_s01", {s00_rdy, s01_rdy, m_tvalid, m_tlast, m_tstrb, m_tdata},
                     {1'b0, m_tready, s_valid[1], s_last[1], s_strb[1], s_data[1]});
        default: check("grant_onehot", 64'(grant), 64'h1);
      endcase
      if (last_xfer_prev) check("bubble", 64'(grant), 64'h0);
      if (grant == 2'b01 && !s_valid[0]) gap_cycles++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("beat port=%0d data=%08h strb=%h last=%0b", e.port, m_tdata, m_tstrb, m_tlast);
          check("beat_data", 64'(m_tdata), 64'(e.data));
          check("beat_strb_last", {m_tstrb, m_tlast}, {e.strb, e.last});
          check("beat_grant", 64'(grant), (e.port == 0) ? 64'h1 : 64'h2);
        end
      end
      last_xfer_prev = m_tvalid && m_tready && m_tlast;
    end
  end

  task automatic load_pkt(input int p, input int n, input logic [DW-1:0] base,
                          input logic [SW-1:0] strb, input int gap_idx, input int gap_len);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i);
      b.strb = strb;
      b.last = (i == n - 1);
      b.gap  = (i == gap_idx) ? gap_len : 0;
      drv_q[p].push_back(b);
    end
  endtask

  task automatic expect_beat(input int p, input logic [DW-1:0] data,
                             input logic [SW-1:0] strb, input logic last);
    exp_t e;
    e.port = p;
    e.data = data;
    e.strb = strb;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic expect_pkt(input int p, input int n, input logic [DW-1:0] base,
                            input logic [SW-1:0] strb);
    for (int i = 0; i < n; i++) expect_beat(p, base + DW'(i), strb, i == n - 1);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while ((drv_q[0].size() != 0 || drv_q[1].size() != 0 || exp_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(n < bound), 64'h1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input int p, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_valid[p] && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("valid_seen", 64'(n < bound), 64'h1);
  endtask

  task automatic do_reset();
    abort = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    drv_q[0].delete();
    drv_q[1].delete();
    exp_q.delete();
    @(negedge clk);
    check("reset_counters", {pkt_cnt0, pkt_cnt1}, '0);
    rst_n = 1'b1;
    abort = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    gap_cycles = 0;
    abort = 1'b0;
    rdy_toggle = 1'b0;
    rst_n = 1'b0;
    m_tready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      s_valid[p] = 1'b0;
      s_last[p]  = 1'b0;
      s_data[p]  = '0;
      s_strb[p]  = '0;
    end

    // Reset state
    #3;
    check("reset_grant", 64'(grant), 64'h0);
    check("reset_cnts", {pkt_cnt0, pkt_cnt1}, '0);
    check("reset_idle", {s00_rdy, s01_rdy, m_tvalid, m_tlast, m_tdata}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single 3-beat packet on s00
    @(negedge clk);
    load_pkt(0, 3, 32'hA, 4'hF, -1, 0);
    expect_beat(0, 32'hA, 4'hF, 1'b0);
    expect_beat(0, 32'hB, 4'hF, 1'b0);
    expect_beat(0, 32'hC, 4'hF, 1'b1);
    wait_valid(0, 10);
    check("t1_grant_before", 64'(grant), 64'h0);
    @(negedge clk);
    check("t1_grant_after", 64'(grant), 64'h1);
    wait_drain("t1", 50);
    check("t1_cnt0", 64'(pkt_cnt0), 64'h1);

    // Both ports busy from reset: alternation s00, s01, s00, s01
    do_reset();
    @(negedge clk);
    load_pkt(0, 2, 32'h100, 4'hF, -1, 0);
    load_pkt(0, 2, 32'h300, 4'h1, -1, 0);
    load_pkt(1, 2, 32'h200, 4'h3, -1, 0);
    load_pkt(1, 2, 32'h400, 4'hC, -1, 0);
    expect_pkt(0, 2, 32'h100, 4'hF);
    expect_pkt(1, 2, 32'h200, 4'h3);
    expect_pkt(0, 2, 32'h300, 4'h1);
    expect_pkt(1, 2, 32'h400, 4'hC);
    wait_drain("t2", 100);
    check("t2_cnts", {pkt_cnt0, pkt_cnt1}, {4'd2, 4'd2});

    // s00 drops tvalid for two cycles mid-packet while s01 waits
    @(negedge clk);
    gap_cycles = 0;
    load_pkt(0, 3, 32'h500, 4'h7, 1, 2);
    load_pkt(1, 1, 32'h600, 4'hE, -1, 0);
    expect_pkt(0, 3, 32'h500, 4'h7);
    expect_pkt(1, 1, 32'h600, 4'hE);
    wait_drain("t3", 100);
    check("t3_gap_cycles", 64'(gap_cycles), 64'd2);
    check("t3_cnts", {pkt_cnt0, pkt_cnt1}, {4'd3, 4'd3});

    // Master ready toggling during a 4-beat packet
    @(negedge clk);
    m_tready = 1'b1;
    rdy_toggle = 1'b1;
    load_pkt(1, 4, 32'h800, 4'h5, -1, 0);
    expect_pkt(1, 4, 32'h800, 4'h5);
    wait_drain("t4", 100);
    rdy_toggle = 1'b0;
    m_tready = 1'b1;
    check("t4_cnts", {pkt_cnt0, pkt_cnt1}, {4'd3, 4'd4});

    // Asynchronous reset in the middle of a stalled packet
    @(negedge clk);
    m_tready = 1'b0;
    load_pkt(0, 4, 32'h700, 4'hF, -1, 0);
    n = 0;
    while (grant != 2'b01 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_granted", 64'(grant), 64'h1);
    #2;
    rst_n = 1'b0;
    abort = 1'b1;
    #1;
    check("t5_async_grant", 64'(grant), 64'h0);
    check("t5_async_cnts", {pkt_cnt0, pkt_cnt1}, '0);
    check("t5_async_idle", {s00_rdy, s01_rdy, m_tvalid, m_tlast, m_tstrb, m_tdata}, '0);
    @(negedge clk);
    drv_q[0].delete();
    drv_q[1].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b0;
    m_tready = 1'b1;
    load_pkt(0, 1, 32'h50, 4'h9, -1, 0);
    load_pkt(1, 1, 32'h51, 4'h6, -1, 0);
    expect_pkt(0, 1, 32'h50, 4'h9);
    expect_pkt(1, 1, 32'h51, 4'h6);
    wait_valid(0, 10);
    check("t5_bubble_first", 64'(grant), 64'h0);
    @(negedge clk);
    check("t5_s00_first", 64'(grant), 64'h1);
    wait_drain("t5", 50);
    check("t5_cnts", {pkt_cnt0, pkt_cnt1}, {4'd1, 4'd1});

    // Counter wrap on s01 (4-bit counters in this bench)
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      load_pkt(1, 1, 32'h900 + DW'(k), 4'hA, -1, 0);
      expect_pkt(1, 1, 32'h900 + DW'(k), 4'hA);
    end
    wait_drain("t6a", 200);
    check("t6_cnt1_full", {pkt_cnt0, pkt_cnt1}, {4'd1, 4'hF});
    load_pkt(1, 1, 32'h9FF, 4'hA, -1, 0);
    expect_pkt(1, 1, 32'h9FF, 4'hA);
    wait_drain("t6b", 50);
    check("t6_cnt1_wrap", {pkt_cnt0, pkt_cnt1}, {4'd1, 4'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
